// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg - shared types and constants for the pipeline hazard controller.
//   state_t : FSM encoding (RUN=0, MEM_WAIT=1, FLUSH=2), also exported on state_o.
//   ctl_t   : bundle of every pipeline-register control the controller drives.
//   CTL_*   : the fixed control patterns the FSM chooses between.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          REG_ZERO  = 0;

  // Bit order, MSB first: five enables, three bubble inserts, PC redirect select.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_sel;
  } ctl_t;

  localparam ctl_t CTL_NORMAL   = ctl_t'(9'b11111_000_0);
  localparam ctl_t CTL_FREEZE   = ctl_t'(9'b00000_000_0);
  localparam ctl_t CTL_REDIRECT = ctl_t'(9'b11111_111_1);
  // Load-use: hold PC and IF/ID, push a bubble into EX, let older stages drain.
  localparam ctl_t CTL_STALL    = ctl_t'(9'b00111_010_0);
  localparam ctl_t CTL_BUBBLE   = ctl_t'(9'b11111_100_0);
  // Reset fills every pipeline register with bubbles on each edge.
  localparam ctl_t CTL_RESET    = ctl_t'(9'b11111_111_0);

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect - combinational hazard terms for the pipeline controller.
//   Inputs : id_rs, id_rt (ID sources), ex_memread, ex_regdest (load in EX),
//            dmem_req, dmem_ready (MEM-stage data memory handshake).
//   Outputs: lu   - ID reads the register a load in EX is about to write.
//            miss - MEM is accessing data memory and it is not finishing this cycle.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_regdest,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             lu,
  output logic             miss
);

  // Register zero is hard-wired, so a load targeting it never creates a dependency.
  assign lu = ex_memread
            & (ex_regdest != REG_W'(REG_ZERO))
            & ((ex_regdest == id_rs) | (ex_regdest == id_rt));

  assign miss = dmem_req & ~dmem_ready;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl - stall/flush sequencer for the 5-stage MIPS pipeline.
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset.
//   id_rs/id_rt, ex_*   : operands for load-use detection.
//   mem_redirect        : taken branch or jump resolved in MEM.
//   dmem_req/dmem_ready : data-memory handshake in MEM.
//   pc_en, *_en         : pipeline register enables.
//   *_flush             : load a bubble instead of data when enabled.
//   pc_sel_redirect     : PC mux takes the branch/jump target.
//   err_timeout         : sticky memory-wait watchdog error.
//   state_o             : current FSM state for debug.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating counters perf_stall,
// perf_flush and perf_wait (CNT_W bits each).
// All controls are decided combinationally in the cycle the condition is seen.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_MAX     = 64
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_regdest,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_sel_redirect,
  output logic             err_timeout,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_wait
`endif
);

  localparam int              WAIT_W         = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT   = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE     = WAIT_W'(1);
  localparam logic [2:0]      FLUSH_INIT     = 3'(FLUSH_CYCLES - 1);
  // With a single flush cycle the redirect cycle itself is the whole flush.
  localparam bit              REDIRECT_HOLDS = (FLUSH_CYCLES > 32'sd1);

  state_t            state_r, next_state_s;
  logic [2:0]        flush_cnt_r, flush_cnt_next_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_next_s;
  logic              err_timeout_r, err_next_s;
  logic              lu_s, miss_s;
  ctl_t              ctl_s, ctl_out_s;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_memread (ex_memread),
    .ex_regdest (ex_regdest),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .lu         (lu_s),
    .miss       (miss_s)
  );

  // State, counters and sticky watchdog error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= RUN;
      flush_cnt_r   <= 3'd0;
      wait_cnt_r    <= '0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      flush_cnt_r   <= flush_cnt_next_s;
      wait_cnt_r    <= wait_cnt_next_s;
      err_timeout_r <= err_next_s;
    end
  end

  // Next-state and control decode; priority is miss > redirect > load-use.
  always_comb begin
    ctl_s            = CTL_NORMAL;
    next_state_s     = state_r;
    flush_cnt_next_s = flush_cnt_r;
    wait_cnt_next_s  = wait_cnt_r;
    err_next_s       = err_timeout_r;
    case (state_r)
      RUN, MEM_WAIT: begin
        if ((state_r == RUN) && miss_s) begin
          ctl_s           = CTL_FREEZE;
          next_state_s    = MEM_WAIT;
          wait_cnt_next_s = WAIT_ONE;
        end else if ((state_r == MEM_WAIT) && !dmem_ready) begin
          ctl_s = CTL_FREEZE;
          if (wait_cnt_r < WAIT_LIMIT) begin
            wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
          end else begin
            wait_cnt_next_s = wait_cnt_r;
          end
          if (wait_cnt_r >= WAIT_LIMIT) begin
            err_next_s = 1'b1;
          end else begin
            err_next_s = err_timeout_r;
          end
        end else begin
          // Normal RUN decode, also used on the memory completion cycle.
          wait_cnt_next_s = '0;
          next_state_s    = RUN;
          if (mem_redirect) begin
            ctl_s = CTL_REDIRECT;
            if (REDIRECT_HOLDS) begin
              next_state_s     = FLUSH;
              flush_cnt_next_s = FLUSH_INIT;
            end else begin
              next_state_s     = RUN;
            end
          end else if (lu_s) begin
            ctl_s = CTL_STALL;
          end else begin
            ctl_s = CTL_NORMAL;
          end
        end
      end
      FLUSH: begin
        if (miss_s) begin
          ctl_s = CTL_FREEZE;
        end else if (mem_redirect) begin
          ctl_s            = CTL_REDIRECT;
          next_state_s     = FLUSH;
          flush_cnt_next_s = FLUSH_INIT;
        end else begin
          // Load-use is irrelevant here: ID holds a bubble.
          ctl_s            = CTL_BUBBLE;
          flush_cnt_next_s = flush_cnt_r - 3'd1;
          if (flush_cnt_r <= 3'd1) begin
            next_state_s = RUN;
          end else begin
            next_state_s = FLUSH;
          end
        end
      end
      default: begin
        ctl_s            = CTL_NORMAL;
        next_state_s     = RUN;
        flush_cnt_next_s = 3'd0;
        wait_cnt_next_s  = '0;
      end
    endcase
  end

  // Reset overrides the decode so every register loads a bubble while it is held.
  always_comb begin
    if (!reset_n) begin
      ctl_out_s = CTL_RESET;
    end else begin
      ctl_out_s = ctl_s;
    end
  end

  assign pc_en           = ctl_out_s.pc_en;
  assign ifid_en         = ctl_out_s.ifid_en;
  assign idex_en         = ctl_out_s.idex_en;
  assign exmem_en        = ctl_out_s.exmem_en;
  assign memwb_en        = ctl_out_s.memwb_en;
  assign ifid_flush      = ctl_out_s.ifid_flush;
  assign idex_flush      = ctl_out_s.idex_flush;
  assign exmem_flush     = ctl_out_s.exmem_flush;
  assign pc_sel_redirect = ctl_out_s.pc_sel;
  assign err_timeout     = err_timeout_r;
  assign state_o         = state_r;

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_evt_s, redirect_evt_s, wait_evt_s;
  logic [CNT_W-1:0] perf_stall_r, perf_flush_r, perf_wait_r;

  assign stall_evt_s    = (ctl_s == CTL_STALL);
  assign redirect_evt_s = ctl_s.pc_sel;
  assign wait_evt_s     = (state_r == MEM_WAIT) && !dmem_ready;

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_r <= '0;
      perf_flush_r <= '0;
      perf_wait_r  <= '0;
    end else begin
      if (stall_evt_s && (perf_stall_r != '1)) perf_stall_r <= perf_stall_r + CNT_W'(1);
      if (redirect_evt_s && (perf_flush_r != '1)) perf_flush_r <= perf_flush_r + CNT_W'(1);
      if (wait_evt_s && (perf_wait_r != '1)) perf_wait_r <= perf_wait_r + CNT_W'(1);
    end
  end

  assign perf_stall = perf_stall_r;
  assign perf_flush = perf_flush_r;
  assign perf_wait  = perf_wait_r;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl - directed and random stimulus for pipeline_hazard_ctrl
// (FLUSH_CYCLES=3, WAIT_MAX=8), checked every cycle against an action-level model.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 3;
  localparam int WM = 8;

  logic       clock, reset_n;
  logic [4:0] id_rs, id_rt, ex_regdest;
  logic       ex_memread, mem_redirect, dmem_req, dmem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, pc_sel_redirect, err_timeout;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush, perf_wait;
`endif

  pipeline_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(FC), .WAIT_MAX(WM)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_memread      (ex_memread),
    .ex_regdest      (ex_regdest),
    .mem_redirect    (mem_redirect),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .pc_sel_redirect (pc_sel_redirect),
    .err_timeout     (err_timeout),
    .state_o         (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall      (perf_stall),
    .perf_flush      (perf_flush),
    .perf_wait       (perf_wait)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [8:0] obs_ctl;
  assign obs_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, pc_sel_redirect};

  int passed = 0;
  int total  = 0;

  // Reference model: what the pipeline is doing, not how the RTL encodes it.
  bit m_waiting;
  int m_flush_left;
  int m_wait_cycles;
  bit m_err;

  localparam int A_RESET = 0, A_FREEZE = 1, A_REDIRECT = 2, A_STALL = 3, A_BUBBLE = 4, A_NORMAL = 5;

  function automatic logic [8:0] action_ctl(int a);
    case (a)
      A_RESET:    return 9'b11111_111_0;
      A_FREEZE:   return 9'b00000_000_0;
      A_REDIRECT: return 9'b11111_111_1;
      A_STALL:    return 9'b00111_010_0;
      A_BUBBLE:   return 9'b11111_100_0;
      default:    return 9'b11111_000_0;
    endcase
  endfunction

  function automatic int pick_action();
    bit miss = dmem_req && !dmem_ready;
    bit lu = ex_memread && (ex_regdest != 5'd0) && ((ex_regdest == id_rs) || (ex_regdest == id_rt));
    if (!reset_n) return A_RESET;
    if (m_waiting && !dmem_ready) return A_FREEZE;
    if (m_flush_left > 0) begin
      if (miss) return A_FREEZE;
      if (mem_redirect) return A_REDIRECT;
      return A_BUBBLE;
    end
    if (miss) return A_FREEZE;
    if (mem_redirect) return A_REDIRECT;
    if (lu) return A_STALL;
    return A_NORMAL;
  endfunction

  task automatic clear_model();
    m_waiting = 1'b0; m_flush_left = 0; m_wait_cycles = 0; m_err = 1'b0;
  endtask

  task automatic advance_model();
    int a = pick_action();
    if (!reset_n) begin
      clear_model();
    end else if (m_waiting) begin
      if (!dmem_ready) begin
        if (m_wait_cycles >= WM) m_err = 1'b1;
        else m_wait_cycles++;
      end else begin
        m_waiting = 1'b0; m_wait_cycles = 0;
        if (a == A_REDIRECT) m_flush_left = FC - 1;
      end
    end else if (a == A_FREEZE) begin
      if (m_flush_left == 0) begin m_waiting = 1'b1; m_wait_cycles = 1; end
    end else if (a == A_REDIRECT) begin
      m_flush_left = FC - 1;
    end else if (a == A_BUBBLE) begin
      m_flush_left--;
    end
  endtask

  task automatic check(string tag, logic [8:0] obs, logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // One clock: check outputs mid-cycle, then step the model at the edge.
  task automatic cycle(string tag);
    logic [1:0] exp_state;
    @(negedge clock);
    if (!reset_n) clear_model();
    exp_state = m_waiting ? 2'd1 : ((m_flush_left > 0) ? 2'd2 : 2'd0);
    check({tag, ":ctl"}, obs_ctl, action_ctl(pick_action()));
    check({tag, ":state"}, {7'd0, state_o}, {7'd0, exp_state});
    check({tag, ":err"}, {8'd0, err_timeout}, {8'd0, m_err});
    @(posedge clock);
    advance_model();
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                       input logic [4:0] rd, input logic redir, input logic req, input logic rdy);
    id_rs = rs; id_rt = rt; ex_memread = mr; ex_regdest = rd;
    mem_redirect = redir; dmem_req = req; dmem_ready = rdy;
  endtask

  initial begin
    clear_model();
    reset_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    // Reset held for three clocks, with hazards presented to prove the override.
    cycle("reset0");
    drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    cycle("reset1");
    cycle("reset2");
    reset_n = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("idle");
    // Load-use on rt, then cleared; then load to $zero.
    drive(5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("lu_rt");
    drive(5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("lu_clear");
    drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("lu_zero");
    drive(5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs");
    // Redirect pulse followed by two bubble cycles.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle("redir");
    drive(5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    cycle("flush1");
    cycle("flush2");
    cycle("after_flush");
    // Four-cycle memory wait.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("mwait");
    dmem_ready = 1'b1;
    cycle("mdone");
    // Everything at once: freeze only; ready arrives with redirect still high.
    drive(5'd4, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    cycle("prio_all");
    dmem_ready = 1'b1;
    cycle("prio_ready");
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("prio_tail");
    // Miss during FLUSH freezes without advancing the flush.
    mem_redirect = 1'b1;
    cycle("fl_redir");
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle("fl_miss");
    dmem_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle("fl_resume");
    // Watchdog: ready stays low well past WAIT_MAX, then reset clears the error.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle("wdog");
    reset_n = 1'b0;
    cycle("wdog_rst");
    reset_n = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("wdog_clear");
    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      reset_n      = ($urandom_range(0, 39) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_regdest   = 5'($urandom_range(0, 3));
      ex_memread   = 1'($urandom_range(0, 1));
      mem_redirect = ($urandom_range(0, 5) == 0);
      dmem_req     = ($urandom_range(0, 2) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      cycle("rand");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
